tick_scheduler: RTL and testbench

//  Shares one free-running prescaler among CHANNELS consumers. Each channel emits a
//  one-cycle tick strobe at its own programmable rate, so the design needs no
//  per-consumer freq_divider. Periods are retuned at runtime through a valid/ready

---
 rtl/tick_scheduler_if.sv | 14 +
 rtl/tick_scheduler.sv | 122 ++++++++++++
 tb/tb_tick_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tick_scheduler_if.sv
// Config port of tick_scheduler: valid/ready request carrying channel, period and enable.
interface tick_scheduler_if #(
    parameter int CH_W = 2,
    parameter int BITS = 8
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_channel;
    logic [BITS-1:0] cfg_period;
    logic            cfg_enable;

    modport master (output cfg_valid, cfg_channel, cfg_period, cfg_enable, input cfg_ready);
    modport slave  (input cfg_valid, cfg_channel, cfg_period, cfg_enable, output cfg_ready);
endinterface

// File: rtl/tick_scheduler.sv
// Shared prescaler driving per-channel tick strobes; tick is 1 cycle after prescale_tick; config stalls (cfg_ready=0)
// until the next prescaler boundary unless TICK_SCHEDULER_IMMEDIATE_EN is defined (then always ready, applies next edge).
module tick_scheduler #(
    parameter int CHANNELS      = 4,
    parameter int BITS          = 8,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    tick_scheduler_if.slave     cfg,
    output logic                prescale_tick,
    output logic [CHANNELS-1:0] tick,
    output logic                busy
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [PRESCALE_BITS-1:0] pcnt;
    logic                     wrap;

    logic            ready;
    logic            apply;
    logic [CH_W-1:0] ap_ch;
    logic [BITS-1:0] ap_per;
    logic            ap_en;

    logic [BITS-1:0]     period [CHANNELS];
    logic [BITS-1:0]     cnt    [CHANNELS];
    logic [CHANNELS-1:0] ch_en;

    assign wrap          = enable && (pcnt == '1);
    assign cfg.cfg_ready = ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcnt          <= '0;
            prescale_tick <= 1'b0;
        end else begin
            if (enable) pcnt <= pcnt + PRESCALE_BITS'(1);
            prescale_tick <= wrap;
        end
    end

`ifdef TICK_SCHEDULER_IMMEDIATE_EN
    assign ready  = 1'b1;
    assign busy   = 1'b0;
    assign apply  = cfg.cfg_valid;
    assign ap_ch  = cfg.cfg_channel;
    assign ap_per = cfg.cfg_period;
    assign ap_en  = cfg.cfg_enable;
`else
    typedef enum logic {IDLE, PENDING} state_t;
    state_t state, state_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ap_ch  <= '0;
            ap_per <= '0;
            ap_en  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cfg.cfg_valid) begin
                ap_ch  <= cfg.cfg_channel;
                ap_per <= cfg.cfg_period;
                ap_en  <= cfg.cfg_enable;
            end
        end
    end

    // The shadow is only released on a prescaler boundary so no channel sees a runt period.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (cfg.cfg_valid) state_nxt = PENDING;
            end
            PENDING: begin
                busy = 1'b1;
                if (prescale_tick) begin
                    apply     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
`endif

    // Expiry uses the old state; a coinciding update then overrides the reload value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick  <= '0;
            ch_en <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            tick <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (prescale_tick && ch_en[i]) begin
                    if (cnt[i] == '0) begin
                        tick[i] <= 1'b1;
                        cnt[i]  <= period[i];
                    end else begin
                        cnt[i] <= cnt[i] - BITS'(1);
                    end
                end
                if (apply && (int'(ap_ch) == i)) begin
                    period[i] <= ap_per;
                    cnt[i]    <= ap_per;
                    ch_en[i]  <= ap_en;
                end
            end
        end
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with a phase-counting reference model and pinned literal timings.
`timescale 1ns/1ps
module tb_tick_scheduler;
    localparam int CHANNELS = 4;
    localparam int BITS     = 8;
    localparam int PB       = 2;
    localparam int CH_W     = 2;
    localparam int PDIV     = 1 << PB;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b1;
    logic                prescale_tick;
    logic [CHANNELS-1:0] tick;
    logic                busy;

    tick_scheduler_if #(.CH_W(CH_W), .BITS(BITS)) cfg_if ();

    tick_scheduler #(.CHANNELS(CHANNELS), .BITS(BITS), .PRESCALE_BITS(PB)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .cfg           (cfg_if),
        .prescale_tick (prescale_tick),
        .tick          (tick),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    bit lit_en  = 1'b1;

    // model state: each enabled channel fires whenever its prescale-tick count since the last
    // update reaches a multiple of period+1
    int                en_edges = 0;
    bit                m_pt = 1'b0;
    bit [CHANNELS-1:0] m_tick = '0;
    bit                m_pend = 1'b0;
    int                sh_ch = 0, sh_per = 0;
    bit                sh_en = 1'b0;
    int                m_per [CHANNELS];
    int                m_k   [CHANNELS];
    bit                m_en  [CHANNELS];
    bit                m_apply;
    int                a_ch, a_per;
    bit                a_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            cyc = 0; en_edges = 0; m_pt = 0; m_tick = '0; m_pend = 0;
            for (int i = 0; i < CHANNELS; i++) begin
                m_per[i] = 0; m_k[i] = 0; m_en[i] = 0;
            end
        end else begin
            cyc++;
            m_tick  = '0;
            m_apply = 1'b0;
`ifdef TICK_SCHEDULER_IMMEDIATE_EN
            if (cfg_if.cfg_valid) begin
                m_apply = 1'b1;
                a_ch = int'(cfg_if.cfg_channel); a_per = int'(cfg_if.cfg_period); a_en = cfg_if.cfg_enable;
            end
`else
            if (m_pend && m_pt) begin
                m_apply = 1'b1; m_pend = 1'b0;
                a_ch = sh_ch; a_per = sh_per; a_en = sh_en;
            end else if (!m_pend && cfg_if.cfg_valid) begin
                m_pend = 1'b1;
                sh_ch = int'(cfg_if.cfg_channel); sh_per = int'(cfg_if.cfg_period); sh_en = cfg_if.cfg_enable;
            end
`endif
            if (m_pt) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (m_en[i]) begin
                        m_k[i]++;
                        if (m_k[i] % (m_per[i] + 1) == 0) m_tick[i] = 1'b1;
                    end
                end
            end
            if (m_apply && a_ch < CHANNELS) begin
                m_per[a_ch] = a_per; m_en[a_ch] = a_en; m_k[a_ch] = 0;
            end
            if (enable) en_edges++;
            m_pt = enable && (en_edges % PDIV == 0);
        end
    end

    always @(posedge clock) begin
        #2;
        check("prescale_tick", prescale_tick, m_pt);
        check("tick", tick, m_tick);
        check("cfg_ready", cfg_if.cfg_ready, !m_pend);
        check("busy", busy, m_pend);
        if (lit_en && !reset) begin
            case (cyc)
                1: begin
                    check("lit_rst_tick", tick, 0);
                    check("lit_rst_busy", busy, 0);
                    check("lit_rst_ready", cfg_if.cfg_ready, 1);
                end
                4: begin
                    check("lit_pt_c4", prescale_tick, 1);
`ifndef TICK_SCHEDULER_IMMEDIATE_EN
                    check("lit_busy_c4", busy, 1);
`endif
                end
                5: begin
                    check("lit_pt_c5", prescale_tick, 0);
                    check("lit_busy_c5", busy, 0);
`ifdef TICK_SCHEDULER_IMMEDIATE_EN
                    check("lit_tick0_c5", tick[0], 1);
`endif
                end
                8: begin
                    check("lit_pt_c8", prescale_tick, 1);
                    check("lit_tick0_c8", tick[0], 0);
                end
                9: begin
                    check("lit_pt_c9", prescale_tick, 0);
                    check("lit_tick0_c9", tick[0], 1);
                end
                10: check("lit_tick0_c10", tick[0], 0);
                12: check("lit_pt_c12", prescale_tick, 1);
                default: ;
            endcase
        end
    end

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic do_cfg(input int ch, input int per, input bit en);
        bit done = 1'b0;
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_channel = CH_W'(ch);
        cfg_if.cfg_period  = BITS'(per);
        cfg_if.cfg_enable  = en;
        for (int i = 0; i < 200 && !done; i++) begin
            done = cfg_if.cfg_ready;
            @(negedge clock);
        end
        cfg_if.cfg_valid = 1'b0;
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL cfg_accept: got ready=0 for 200 cycles, required ready=1 (ch %0d)", ch);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: got no event within bound, required one", name);
    endtask

    initial begin
        int t1, t2, n;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_channel = '0; cfg_if.cfg_period = '0; cfg_if.cfg_enable = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        do_cfg(0, 0, 1);
        do_cfg(1, 2, 1);
        do_cfg(2, 5, 1);
        repeat (60) @(negedge clock);

        // align a ch1 update so it lands on the prescale tick where ch1 expires
        n = 0;
        while (!((m_k[1] % 3 == 2) && !m_pt && !m_pend) && n < 100) begin
            @(negedge clock); n++;
        end
        if (n >= 100) timeout_fail("ch1_align");
        do_cfg(1, 1, 1);
        n = 0;
        while (!tick[1] && n < 40) begin @(negedge clock); n++; end
        t1 = cyc;
        @(negedge clock);
        n = 0;
        while (!tick[1] && n < 40) begin @(negedge clock); n++; end
        t2 = cyc;
`ifndef TICK_SCHEDULER_IMMEDIATE_EN
        check("ch1_reload_gap", t2 - t1, 8);
`endif
        lit_en = 1'b0;

        // stall the prescaler with an update pending
        n = 0;
        while (!(m_pt && !m_pend) && n < 40) begin @(negedge clock); n++; end
        if (n >= 40) timeout_fail("pt_align");
        do_cfg(3, 3, 1);
        enable = 1'b0;
        repeat (20) begin
            @(negedge clock);
            check("stall_pt", prescale_tick, 0);
            check("stall_tick", tick, 0);
`ifndef TICK_SCHEDULER_IMMEDIATE_EN
            check("stall_ready", cfg_if.cfg_ready, 0);
`endif
        end
        enable = 1'b1;
        repeat (40) @(negedge clock);

        // reset while an update is pending
        do_cfg(2, 1, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_ready", cfg_if.cfg_ready, 1);
        check("rst_tick", tick, 0);
        repeat (40) @(negedge clock);
        do_cfg(3, 0, 1);
        repeat (20) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200us");
        $fatal(1, "watchdog");
    end
endmodule
